counter_mod_updn: RTL and testbench

COUNTER_MOD_UPDN -- requirements
Module: counter_mod_updn

---
 rtl/counter_mod_updn.sv | 99 +++++++++
 tb/tb_counter_mod_updn.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/counter_mod_updn.sv
// Modulo up/down counter with carry/borrow pulse, clear and saturating load.
// Optional prescaler compiled in with `define COUNTER_PRESCALE_EN (adds I_div port).
module counter_mod_updn #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned MODULO = 256,
  parameter int unsigned PRE_W  = 4
) (
  input  logic             I_clk,
  input  logic             I_rst_n,
  input  logic             I_en,
  input  logic             I_up,
  input  logic             I_clr,
  input  logic             I_load,
  input  logic [WIDTH-1:0] I_load_val,
`ifdef COUNTER_PRESCALE_EN
  input  logic [PRE_W-1:0] I_div,
`endif
  output logic [WIDTH-1:0] O_cnt,
  output logic             O_cout
);

  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MODULO - 1);

  if ((MODULO < 2) || (64'(MODULO) > (64'd1 << WIDTH)) || (PRE_W < 1)) begin : g_bad_param
    $error("counter_mod_updn: illegal WIDTH/MODULO/PRE_W combination");
  end

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             cout_q, cout_d;
  logic             step;

`ifdef COUNTER_PRESCALE_EN
  logic [PRE_W-1:0] pre_q, pre_d;

  // Step fires on the enabled edge where the prescaler matches the divisor.
  always_comb begin
    pre_d = pre_q;
    step  = 1'b0;
    if (I_en) begin
      if (pre_q == I_div) begin
        step  = 1'b1;
        pre_d = '0;
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end
  end

  always_ff @(posedge I_clk) begin
    if (!I_rst_n || I_clr || I_load) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end
`else
  assign step = I_en;
`endif

  always_comb begin
    cnt_d  = cnt_q;
    cout_d = 1'b0;
    if (I_clr) begin
      cnt_d = '0;
    end else if (I_load) begin
      cnt_d = (I_load_val > CNT_MAX) ? CNT_MAX : I_load_val;
    end else if (step) begin
      if (I_up) begin
        if (cnt_q == CNT_MAX) begin
          cnt_d  = '0;
          cout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        if (cnt_q == '0) begin
          cnt_d  = CNT_MAX;
          cout_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      cnt_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      cout_q <= cout_d;
    end
  end

  assign O_cnt  = cnt_q;
  assign O_cout = cout_q;

endmodule

// File: tb/tb_counter_mod_updn.sv
// Scoreboard bench for counter_mod_updn (WIDTH=8, MODULO=10); prescaler section
// runs only when COUNTER_PRESCALE_EN is defined.
module tb_counter_mod_updn;

  localparam int W = 8;
  localparam int M = 10;

  logic         clk = 1'b0;
  logic         rst_n, en, up, clr, load;
  logic [W-1:0] load_val;
  logic [W-1:0] cnt;
  logic         cout;
`ifdef COUNTER_PRESCALE_EN
  logic [3:0]   div = 4'd0;
  int           m_pre = 0;
`endif

  typedef struct {
    string tag;
    int    cnt;
    int    cout;
  } exp_t;

  exp_t sb[$];
  int   m_cnt = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  counter_mod_updn #(
    .WIDTH (W),
    .MODULO(M),
    .PRE_W (4)
  ) dut (
    .I_clk     (clk),
    .I_rst_n   (rst_n),
    .I_en      (en),
    .I_up      (up),
    .I_clr     (clr),
    .I_load    (load),
    .I_load_val(load_val),
`ifdef COUNTER_PRESCALE_EN
    .I_div     (div),
`endif
    .O_cnt     (cnt),
    .O_cout    (cout)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one clock of inputs, predict the result, then compare after the edge.
  task automatic cyc(input string tag, input logic r, input logic c, input logic ld,
                     input logic e, input logic u, input int lv);
    exp_t x;
    bit   do_step;
    rst_n = r; clr = c; load = ld; en = e; up = u; load_val = W'(lv);
    x.tag  = tag;
    x.cout = 0;
    if (!r || c) begin
      m_cnt = 0;
`ifdef COUNTER_PRESCALE_EN
      m_pre = 0;
`endif
    end else if (ld) begin
      m_cnt = (lv >= M) ? M - 1 : lv;
`ifdef COUNTER_PRESCALE_EN
      m_pre = 0;
`endif
    end else begin
`ifdef COUNTER_PRESCALE_EN
      do_step = 1'b0;
      if (e) begin
        if (m_pre == int'(div)) begin
          do_step = 1'b1;
          m_pre   = 0;
        end else begin
          m_pre = (m_pre + 1) % 16;
        end
      end
`else
      do_step = e;
`endif
      if (do_step) begin
        if (u) begin
          x.cout = (m_cnt == M - 1) ? 1 : 0;
          m_cnt  = (m_cnt + 1) % M;
        end else begin
          x.cout = (m_cnt == 0) ? 1 : 0;
          m_cnt  = (m_cnt + M - 1) % M;
        end
      end
    end
    x.cnt = m_cnt;
    sb.push_back(x);
    @(posedge clk);
    #1;
    check({tag, "_sb"}, sb.size(), 1);
    if (sb.size() > 0) begin
      x = sb.pop_front();
      check({x.tag, "_cnt"}, int'(cnt), x.cnt);
      check({x.tag, "_cout"}, int'(cout), x.cout);
    end
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; load = 1'b0; en = 1'b0; up = 1'b1; load_val = '0;

    cyc("reset", 0, 0, 0, 1, 1, 0);
    cyc("reset", 0, 0, 0, 1, 1, 0);

    // Up wrap: 0..9,0,1 with a single carry pulse.
    for (int i = 0; i < 12; i++) cyc("up", 1, 0, 0, 1, 1, 0);
    check("up_after12", int'(cnt), 2);

    // Down wrap from 0.
    cyc("clr", 1, 1, 0, 1, 1, 0);
    for (int i = 0; i < 11; i++) cyc("down", 1, 0, 0, 1, 0, 0);

    // Hold.
    for (int i = 0; i < 3; i++) cyc("hold", 1, 0, 0, 0, 1, 0);

    // Load / clear priority and saturation.
    cyc("load7", 1, 0, 1, 1, 1, 7);
    check("load7_abs", int'(cnt), 7);
    cyc("load12", 1, 0, 1, 1, 1, 12);
    check("load12_sat", int'(cnt), 9);
    cyc("load255", 1, 0, 1, 1, 0, 255);
    cyc("clr_load", 1, 1, 1, 1, 1, 5);
    check("clr_load_abs", int'(cnt), 0);

    // Direction change at terminal value: no wrap, no carry.
    cyc("load9", 1, 0, 1, 0, 1, 9);
    cyc("dirchg", 1, 0, 0, 1, 0, 0);
    check("dirchg_abs", int'(cnt), 8);
    cyc("dirchg_back", 1, 0, 0, 1, 1, 0);

    // Mid-count reset: no effect until the edge.
    cyc("clr", 1, 1, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) cyc("to5", 1, 0, 0, 1, 1, 0);
    rst_n = 1'b0; en = 1'b1;
    #1;
    check("rst_pre_edge", int'(cnt), 5);
    for (int i = 0; i < 3; i++) cyc("rst_mid", 0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 2; i++) cyc("resume", 1, 0, 0, 1, 1, 0);

`ifdef COUNTER_PRESCALE_EN
    div = 4'd2;
    cyc("pre_rst", 0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 7; i++) cyc("pre_run", 1, 0, 0, 1, 1, 0);
    for (int i = 0; i < 2; i++) cyc("pre_freeze", 1, 0, 0, 0, 1, 0);
    for (int i = 0; i < 6; i++) cyc("pre_run2", 1, 0, 0, 1, 1, 0);
    check("pre_abs", int'(cnt), 4);
`endif

    // Randomised mix of all controls.
    for (int i = 0; i < 300; i++) begin
      cyc("rand",
          logic'($urandom_range(0, 19) != 0),
          logic'($urandom_range(0, 14) == 0),
          logic'($urandom_range(0, 11) == 0),
          logic'($urandom_range(0, 3) != 0),
          logic'($urandom_range(0, 1)),
          int'($urandom_range(0, 255)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
